fu_thold_seq: RTL and testbench

//  Sequences FU clock-domain holds (thold) and scan gating into fu_perv's _3 inputs.

---
 rtl/fu_perv_pkg.sv | 23 ++
 rtl/fu_thold_gap_cnt.sv | 33 +++
 rtl/fu_thold_seq.sv | 172 +++++++++++++++++
 tb/tb_fu_thold_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fu_perv_pkg.sv
// Shared FU pervasive definitions: thold domain indices and the thold sequencer state encoding.
package fu_perv_pkg;

  localparam int N_DOM_DEF = 8;

  localparam int DOM_GPTR     = 0;
  localparam int DOM_CFG      = 1;
  localparam int DOM_TIME     = 2;
  localparam int DOM_ABST     = 3;
  localparam int DOM_ARY_NSL  = 4;
  localparam int DOM_REPR     = 5;
  localparam int DOM_FUNC_SLP = 6;
  localparam int DOM_FUNC     = 7;

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RELEASE,
    ST_RUNNING,
    ST_ASSERT,
    ST_SCAN
  } seq_state_e;

endpackage

// File: rtl/fu_thold_gap_cnt.sv
// Inter-domain gap down-counter shared by the release and assert sequences.
// A load value of zero is treated as one so every step takes at least one cycle.
module fu_thold_gap_cnt #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [GAP_W-1:0] val_i,
  output logic             expire_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (val_i == '0) ? GAP_W'(1) : val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/fu_thold_seq.sv
// FU thold / scan-gate sequencer: ordered domain release and reverse-order re-assertion.
// Optional completed-start counter enabled by FU_THOLD_SEQ_CNT_EN.
module fu_thold_seq
  import fu_perv_pkg::*;
#(
  parameter int N_DOM = N_DOM_DEF,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req,
  input  logic             stop_req,
  input  logic             scan_req,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             seq_ack,
  output logic             seq_busy,
  output logic [N_DOM-1:0] thold_3,
  output logic [1:0]       sg_3,
  output logic             fce_3,
  output logic [15:0]      seq_count
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] thold_q, thold_d;
  logic             sg_q, sg_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             gap_load, gap_dec, gap_expire;

  fu_thold_gap_cnt #(.GAP_W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (gap_load),
    .dec_i    (gap_dec),
    .val_i    (cfg_gap),
    .expire_o (gap_expire)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    thold_d  = thold_q;
    sg_d     = sg_q;
    ack_d    = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (start_req && !stop_req && !scan_req) begin
          state_d  = ST_RELEASE;
          idx_d    = '0;
          gap_load = 1'b1;
        end else if (scan_req && !start_req && !ack_q) begin
          // Held off one cycle after a stop ack so acks never run back to back.
          state_d = ST_SCAN;
          sg_d    = 1'b1;
          ack_d   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stop_req) begin
          if (idx_q == '0) begin
            state_d = ST_STOPPED;
            ack_d   = 1'b1;
          end else begin
            state_d  = ST_ASSERT;
            idx_d    = idx_q - IDX_W'(1);
            gap_load = 1'b1;
          end
        end else if (gap_expire) begin
          thold_d[idx_q] = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUNNING;
            ack_d   = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            gap_load = 1'b1;
          end
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (stop_req) begin
          state_d  = ST_ASSERT;
          idx_d    = IDX_LAST;
          gap_load = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (gap_expire) begin
          thold_d[idx_q] = 1'b1;
          if (idx_q == '0) begin
            state_d = ST_STOPPED;
            ack_d   = 1'b1;
          end else begin
            idx_d    = idx_q - IDX_W'(1);
            gap_load = 1'b1;
          end
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!scan_req && !ack_q) begin
          state_d = ST_STOPPED;
          sg_d    = 1'b0;
          ack_d   = 1'b1;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    busy_d = (state_d == ST_RELEASE) || (state_d == ST_ASSERT);
  end

  // Reset is a cold event: all holds return at once rather than in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      idx_q   <= '0;
      thold_q <= '1;
      sg_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      thold_q <= thold_d;
      sg_q    <= sg_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FU_THOLD_SEQ_CNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if ((state_q == ST_RELEASE) && (state_d == ST_RUNNING) && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign seq_count = count_q;
`else
  assign seq_count = 16'h0000;
`endif

  assign seq_ack  = ack_q;
  assign seq_busy = busy_q;
  assign thold_3  = thold_q;
  assign sg_3     = {2{sg_q}};
  assign fce_3    = sg_q;

  // Released domains always form a contiguous low range 0..k-1.
  logic [N_DOM-1:0] released;
  assign released = ~thold_q;

  a_thold_suffix: assert property (@(posedge clk) disable iff (rst)
    (released & (released + N_DOM'(1))) == '0);

  a_ack_single: assert property (@(posedge clk) disable iff (rst)
    seq_ack |=> !seq_ack);

endmodule

// File: tb/tb_fu_thold_seq.sv
// Directed self-checking bench for fu_thold_seq; expected seq_count follows FU_THOLD_SEQ_CNT_EN.
module tb_fu_thold_seq;

  logic        clk;
  logic        rst;
  logic        start_req;
  logic        stop_req;
  logic        scan_req;
  logic [3:0]  cfg_gap;
  logic        seq_ack;
  logic        seq_busy;
  logic [7:0]  thold_3;
  logic [1:0]  sg_3;
  logic        fce_3;
  logic [15:0] seq_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FU_THOLD_SEQ_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  fu_thold_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .stop_req  (stop_req),
    .scan_req  (scan_req),
    .cfg_gap   (cfg_gap),
    .seq_ack   (seq_ack),
    .seq_busy  (seq_busy),
    .thold_3   (thold_3),
    .sg_3      (sg_3),
    .fce_3     (fce_3),
    .seq_count (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sampling and driving happen 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  logic [7:0] exp_th;
  int         acks;

  initial begin
    logic [7:0] t3 [4];
    t3 = '{8'hF8, 8'hFC, 8'hFE, 8'hFF};

    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; scan_req = 1'b0; cfg_gap = 4'd0;
    tick(); tick();
    check("rst_thold", 32'(thold_3), 32'hFF);
    check("rst_sg",    32'(sg_3),    32'h0);
    check("rst_fce",   32'(fce_3),   32'h0);
    check("rst_ack",   32'(seq_ack), 32'h0);
    check("rst_busy",  32'(seq_busy), 32'h0);
    check("rst_count", 32'(seq_count), 32'h0);
    rst = 1'b0;
    tick();

    // 1: ordered release with gap 2
    cfg_gap = 4'd2; start_req = 1'b1;
    tick();
    check("t1_entry_busy",  32'(seq_busy), 32'h1);
    check("t1_entry_thold", 32'(thold_3),  32'hFF);
    start_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_th = 8'hFF << (k / 2);
      check($sformatf("t1_thold_k%0d", k), 32'(thold_3), 32'(exp_th));
      check($sformatf("t1_ack_k%0d", k),   32'(seq_ack), 32'(k == 16));
      check($sformatf("t1_busy_k%0d", k),  32'(seq_busy), 32'(k < 16));
    end
    check("t1_count", 32'(seq_count), 32'(cnt_exp(1)));
    tick();
    check("t1_ack_drop", 32'(seq_ack), 32'h0);

    // 2: descending re-assert with gap 1
    cfg_gap = 4'd1; stop_req = 1'b1;
    tick();
    check("t2_entry_busy",  32'(seq_busy), 32'h1);
    check("t2_entry_thold", 32'(thold_3),  32'h00);
    stop_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_th = 8'hFF << (8 - k);
      check($sformatf("t2_thold_k%0d", k), 32'(thold_3), 32'(exp_th));
      check($sformatf("t2_ack_k%0d", k),   32'(seq_ack), 32'(k == 8));
    end
    tick();
    check("t2_idle_busy", 32'(seq_busy), 32'h0);
    check("t2_idle_ack",  32'(seq_ack),  32'h0);

    // 3: stop after bit2 released, gap 3
    cfg_gap = 4'd3; start_req = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) tick();
    check("t3_partial_thold", 32'(thold_3), 32'hF8);
    stop_req = 1'b1; start_req = 1'b0;
    tick();
    check("t3_abort_thold", 32'(thold_3), 32'hF8);
    check("t3_abort_ack",   32'(seq_ack),  32'h0);
    check("t3_abort_busy",  32'(seq_busy), 32'h1);
    stop_req = 1'b0;
    acks = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      acks += int'(seq_ack);
      check($sformatf("t3_thold_k%0d", k), 32'(thold_3), 32'(t3[k / 3]));
    end
    check("t3_final_ack", 32'(seq_ack), 32'h1);
    tick();
    acks += int'(seq_ack);
    check("t3_ack_total", 32'(acks), 32'd1);
    check("t3_count",     32'(seq_count), 32'(cnt_exp(1)));

    // 3b: stop before anything released goes straight to STOPPED
    start_req = 1'b1;
    tick();
    start_req = 1'b0; stop_req = 1'b1;
    tick();
    check("t3b_ack",   32'(seq_ack),  32'h1);
    check("t3b_busy",  32'(seq_busy), 32'h0);
    check("t3b_thold", 32'(thold_3),  32'hFF);
    stop_req = 1'b0;
    tick();

    // 4: start and stop together from STOPPED
    start_req = 1'b1; stop_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t4_thold_k%0d", k), 32'(thold_3), 32'hFF);
      check($sformatf("t4_ack_k%0d", k),   32'(seq_ack), 32'h0);
      check($sformatf("t4_busy_k%0d", k),  32'(seq_busy), 32'h0);
    end
    start_req = 1'b0; stop_req = 1'b0;
    tick();

    // 5: scan gate on, start ignored, scan gate off
    scan_req = 1'b1;
    tick();
    check("t5_sg_on",  32'(sg_3),    32'h3);
    check("t5_fce_on", 32'(fce_3),   32'h1);
    check("t5_ack_on", 32'(seq_ack), 32'h1);
    start_req = 1'b1;
    tick(); tick();
    check("t5_sg_hold",    32'(sg_3),     32'h3);
    check("t5_thold_hold", 32'(thold_3),  32'hFF);
    check("t5_busy_hold",  32'(seq_busy), 32'h0);
    check("t5_ack_hold",   32'(seq_ack),  32'h0);
    start_req = 1'b0; scan_req = 1'b0;
    tick();
    check("t5_sg_off",  32'(sg_3),    32'h0);
    check("t5_fce_off", 32'(fce_3),   32'h0);
    check("t5_ack_off", 32'(seq_ack), 32'h1);
    tick();
    check("t5_ack_drop", 32'(seq_ack), 32'h0);

    // 6: reset mid-release, then two full starts (second with gap 0)
    cfg_gap = 4'd1; start_req = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    check("t6_mid_thold", 32'(thold_3),  32'hF0);
    check("t6_pre_count", 32'(seq_count), 32'(cnt_exp(1)));
    rst = 1'b1;
    tick();
    check("t6_rst_thold", 32'(thold_3),  32'hFF);
    check("t6_rst_busy",  32'(seq_busy), 32'h0);
    check("t6_rst_count", 32'(seq_count), 32'h0);
    rst = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    check("t6_s1_thold", 32'(thold_3), 32'h00);
    check("t6_s1_ack",   32'(seq_ack), 32'h1);
    start_req = 1'b0; stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check("t6_stop_thold", 32'(thold_3), 32'hFF);
    check("t6_stop_ack",   32'(seq_ack), 32'h1);
    cfg_gap = 4'd0;
    tick();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check("t6_gap0_thold7", 32'(thold_3), 32'h80);
    tick();
    check("t6_s2_thold", 32'(thold_3),  32'h00);
    check("t6_s2_ack",   32'(seq_ack),  32'h1);
    check("t6_s2_count", 32'(seq_count), 32'(cnt_exp(2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
